// File: rtl/fll_cfg_pkg.sv
// Shared constants for the FLL configuration responder: register map
// addresses, FSM state encoding, reset defaults and status field layout.
package fll_cfg_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    // Register map addresses
    localparam logic [ADDR_W-1:0] FLL_STATUS = 2'd0;
    localparam logic [ADDR_W-1:0] FLL_CFG1   = 2'd1;
    localparam logic [ADDR_W-1:0] FLL_CFG2   = 2'd2;
    localparam logic [ADDR_W-1:0] FLL_INTEG  = 2'd3;

    // Handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_REL = 2'd3
    } fll_state_e;

    // Default reset values
    localparam logic [DATA_W-1:0] FLL_CFG1_RST  = 32'h0000_05F5;
    localparam logic [DATA_W-1:0] FLL_CFG2_RST  = 32'h0004_0107;
    localparam logic [DATA_W-1:0] FLL_INTEG_RST = 32'h0000_0000;

    // Status word layout
    localparam int unsigned LOCK_BIT = 31;
    localparam int unsigned MULT_LSB = 0;
    localparam int unsigned MULT_W   = 16;

endpackage

// File: rtl/fll_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous control bit.
// Ports:
//   HCLK    - destination-domain clock
//   HRESETn - asynchronous active-low reset, clears every stage
//   d_i     - asynchronous input bit
//   q_o     - synchronised output (STAGES flops after d_i)
// STAGES must be at least 2.
module fll_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain: bit 0 is the metastability-exposed stage
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fll_cfg_responder.sv
// FLL-side responder of the 4-phase req/ack configuration link.
// Synchronises cfg_req, decodes read/write on a 4-entry register map and
// returns ack plus read data to the bridge.
// Ports:
//   HCLK, HRESETn          - FLL clock, async active-low reset
//   cfg_req                - async request from bridge
//   cfg_wrn/cfg_add/cfg_data - bundled with cfg_req (1 = read)
//   cfg_ack, cfg_r_data    - acknowledge and read data to bridge
//   cfg1_o, cfg2_o, integ_o - configuration registers to the FLL core
//   integ_ld_o, cfg_upd_o  - one-cycle update strobes
//   status_i, integ_i      - live status / integrator value from core
module fll_cfg_responder
    import fll_cfg_pkg::*;
#(
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [31:0]      CFG1_RST    = FLL_CFG1_RST,
    parameter logic [31:0]      CFG2_RST    = FLL_CFG2_RST,
    parameter logic [31:0]      INTEG_RST   = FLL_INTEG_RST
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cfg_req,
    input  logic        cfg_wrn,
    input  logic [1:0]  cfg_add,
    input  logic [31:0] cfg_data,
    output logic        cfg_ack,
    output logic [31:0] cfg_r_data,
    output logic [31:0] cfg1_o,
    output logic [31:0] cfg2_o,
    output logic [31:0] integ_o,
    output logic        integ_ld_o,
    output logic        cfg_upd_o,
    input  logic [31:0] status_i,
    input  logic [31:0] integ_i
);

    logic req_s;

    fll_state_e        state_q, state_d;
    logic              wrn_q, wrn_d;
    logic [ADDR_W-1:0] add_q, add_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] cfg1_q, cfg1_d;
    logic [DATA_W-1:0] cfg2_q, cfg2_d;
    logic [DATA_W-1:0] integ_q, integ_d;
    logic              ack_q, ack_d;
    logic              upd_q, upd_d;
    logic              ld_q, ld_d;

    fll_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .d_i     (cfg_req),
        .q_o     (req_s)
    );

    // State and output registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            wrn_q   <= 1'b0;
            add_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            cfg1_q  <= CFG1_RST;
            cfg2_q  <= CFG2_RST;
            integ_q <= INTEG_RST;
            ack_q   <= 1'b0;
            upd_q   <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wrn_q   <= wrn_d;
            add_q   <= add_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            cfg1_q  <= cfg1_d;
            cfg2_q  <= cfg2_d;
            integ_q <= integ_d;
            ack_q   <= ack_d;
            upd_q   <= upd_d;
            ld_q    <= ld_d;
        end
    end

    // Next-state and register-update decode
    always_comb begin
        state_d = state_q;
        wrn_d   = wrn_q;
        add_d   = add_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        cfg1_d  = cfg1_q;
        cfg2_d  = cfg2_q;
        integ_d = integ_q;
        ack_d   = ack_q;
        upd_d   = 1'b0;
        ld_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                // Bundled signals are stable once req_s is seen high
                if (req_s) begin
                    wrn_d   = cfg_wrn;
                    add_d   = cfg_add;
                    data_d  = cfg_data;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wrn_q) begin
                    case (add_q)
                        FLL_STATUS: rdata_d = status_i;
                        FLL_CFG1:   rdata_d = cfg1_q;
                        FLL_CFG2:   rdata_d = cfg2_q;
                        default:    rdata_d = integ_i;
                    endcase
                end else begin
                    case (add_q)
                        FLL_CFG1: begin
                            cfg1_d = data_q;
                            upd_d  = 1'b1;
                        end
                        FLL_CFG2: begin
                            cfg2_d = data_q;
                            upd_d  = 1'b1;
                        end
                        FLL_INTEG: begin
                            integ_d = data_q;
                            ld_d    = 1'b1;
                        end
                        default: ;  // STATUS is read-only
                    endcase
                end
                // Ack registers on the same edge that enters ACK
                ack_d   = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // Always complete one ack cycle, even if req already dropped
                ack_d   = 1'b1;
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg_ack    = ack_q;
    assign cfg_r_data = rdata_q;
    assign cfg1_o     = cfg1_q;
    assign cfg2_o     = cfg2_q;
    assign integ_o    = integ_q;
    assign integ_ld_o = ld_q;
    assign cfg_upd_o  = upd_q;

endmodule

// File: tb/tb_fll_cfg_responder.sv
// Randomised self-checking bench for fll_cfg_responder against a
// register-map reference model kept in plain variables.
module tb_fll_cfg_responder;

    localparam int unsigned SYNC = 2;

    logic        HCLK;
    logic        HRESETn;
    logic        cfg_req;
    logic        cfg_wrn;
    logic [1:0]  cfg_add;
    logic [31:0] cfg_data;
    logic        cfg_ack;
    logic [31:0] cfg_r_data;
    logic [31:0] cfg1_o;
    logic [31:0] cfg2_o;
    logic [31:0] integ_o;
    logic        integ_ld_o;
    logic        cfg_upd_o;
    logic [31:0] status_i;
    logic [31:0] integ_i;

    // Reference model state
    logic [31:0] m_cfg1, m_cfg2, m_integ, m_rdata;

    int n_chk = 0;
    int n_bad = 0;

    fll_cfg_responder #(.SYNC_STAGES(SYNC)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .cfg_req    (cfg_req),
        .cfg_wrn    (cfg_wrn),
        .cfg_add    (cfg_add),
        .cfg_data   (cfg_data),
        .cfg_ack    (cfg_ack),
        .cfg_r_data (cfg_r_data),
        .cfg1_o     (cfg1_o),
        .cfg2_o     (cfg2_o),
        .integ_o    (integ_o),
        .integ_ld_o (integ_ld_o),
        .cfg_upd_o  (cfg_upd_o),
        .status_i   (status_i),
        .integ_i    (integ_i)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cfg1  = 32'h0000_05F5;
        m_cfg2  = 32'h0004_0107;
        m_integ = 32'h0000_0000;
        m_rdata = 32'h0000_0000;
    endtask

    // Effect of one completed transaction on the register map
    task automatic model_apply(input logic wrn, input logic [1:0] add,
                               input logic [31:0] data);
        if (wrn) begin
            case (add)
                2'd0:    m_rdata = status_i;
                2'd1:    m_rdata = m_cfg1;
                2'd2:    m_rdata = m_cfg2;
                default: m_rdata = integ_i;
            endcase
        end else if (add == 2'd1) m_cfg1 = data;
        else if (add == 2'd2)     m_cfg2 = data;
        else if (add == 2'd3)     m_integ = data;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_cfg1"},  cfg1_o,     m_cfg1);
        check({tag, "_cfg2"},  cfg2_o,     m_cfg2);
        check({tag, "_integ"}, integ_o,    m_integ);
        check({tag, "_rdata"}, cfg_r_data, m_rdata);
    endtask

    // One full 4-phase handshake; hold = extra cycles req stays high after ack
    task automatic run_txn(input string tag, input logic wrn, input logic [1:0] add,
                           input logic [31:0] data, input int hold,
                           input logic [31:0] st, input logic [31:0] iv);
        int n, upd_cnt, ld_cnt, exp_upd, exp_ld;
        status_i = st;
        integ_i  = iv;
        exp_upd  = (!wrn && (add == 2'd1 || add == 2'd2)) ? 1 : 0;
        exp_ld   = (!wrn && add == 2'd3) ? 1 : 0;
        upd_cnt  = 0;
        ld_cnt   = 0;
        @(negedge HCLK);
        cfg_wrn  = wrn;
        cfg_add  = add;
        cfg_data = data;
        cfg_req  = 1'b1;
        n = 0;
        do begin
            @(posedge HCLK); #1;
            n++;
            upd_cnt += int'(cfg_upd_o);
            ld_cnt  += int'(integ_ld_o);
            if (cfg_upd_o) check({tag, "_upd_vis"}, (add == 2'd1) ? cfg1_o : cfg2_o, data);
            if (integ_ld_o) check({tag, "_ld_vis"}, integ_o, data);
        end while (!cfg_ack && n < 20);
        check({tag, "_ack_rise_lat"}, 32'(n), 32'(SYNC + 2));
        model_apply(wrn, add, data);
        for (int h = 0; h < hold; h++) begin
            check({tag, "_ack_hold"}, 32'(cfg_ack), 32'd1);
            check({tag, "_rdata_hold"}, cfg_r_data, m_rdata);
            @(posedge HCLK); #1;
            upd_cnt += int'(cfg_upd_o);
            ld_cnt  += int'(integ_ld_o);
        end
        cfg_req = 1'b0;
        n = 0;
        do begin
            @(posedge HCLK); #1;
            n++;
            upd_cnt += int'(cfg_upd_o);
            ld_cnt  += int'(integ_ld_o);
        end while (cfg_ack && n < 20);
        check({tag, "_ack_fall_lat"}, 32'(n), 32'(SYNC + 1));
        check({tag, "_upd_cnt"}, 32'(upd_cnt), 32'(exp_upd));
        check({tag, "_ld_cnt"},  32'(ld_cnt),  32'(exp_ld));
        check_regs(tag);
    endtask

    initial begin
        int n, ack_cycles;
        logic [1:0] a;
        HRESETn  = 1'b0;
        cfg_req  = 1'b0;
        cfg_wrn  = 1'b0;
        cfg_add  = 2'd0;
        cfg_data = '0;
        status_i = '0;
        integ_i  = '0;
        model_reset();

        // Reset values
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_ack", 32'(cfg_ack), 32'd0);
        check("rst_upd", 32'(cfg_upd_o), 32'd0);
        check("rst_ld",  32'(integ_ld_o), 32'd0);
        check_regs("rst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check_regs("post_rst");

        // Directed cases
        run_txn("wr_cfg1",   1'b0, 2'd1, 32'hDEAD_BEEF, 2, 32'h0, 32'h0);
        run_txn("rd_status", 1'b1, 2'd0, 32'h0,         3, 32'h8000_0123, 32'h0);
        run_txn("wr_integ",  1'b0, 2'd3, 32'h55,        1, 32'h0, 32'h0);
        run_txn("rd_integ",  1'b1, 2'd3, 32'h0,         2, 32'h0, 32'h77);
        run_txn("wr_status", 1'b0, 2'd0, 32'hFFFF_FFFF, 1, 32'h1, 32'h2);
        run_txn("rd_cfg2",   1'b1, 2'd2, 32'h0,         1, 32'h3, 32'h4);

        // Short request pulse: transaction still completes, ack still pulses
        @(negedge HCLK);
        cfg_wrn = 1'b0; cfg_add = 2'd2; cfg_data = 32'hA5A5_0F0F; cfg_req = 1'b1;
        repeat (SYNC) @(posedge HCLK);
        #1;
        cfg_req = 1'b0;
        n = 0; ack_cycles = 0;
        while (n < 20) begin
            @(posedge HCLK); #1;
            n++;
            ack_cycles += int'(cfg_ack);
            if (ack_cycles > 0 && !cfg_ack) break;
        end
        model_apply(1'b0, 2'd2, 32'hA5A5_0F0F);
        check("short_ack_seen", 32'(ack_cycles >= 1), 32'd1);
        check("short_ack_drop", 32'(cfg_ack), 32'd0);
        check_regs("short");

        // Reset mid-handshake with request kept high
        @(negedge HCLK);
        cfg_wrn = 1'b0; cfg_add = 2'd1; cfg_data = 32'h1234_5678; cfg_req = 1'b1;
        n = 0;
        do begin @(posedge HCLK); #1; n++; end while (!cfg_ack && n < 20);
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check("midrst_ack", 32'(cfg_ack), 32'd0);
        check_regs("midrst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        n = 0;
        do begin @(posedge HCLK); #1; n++; end while (!cfg_ack && n < 20);
        check("midrst_rehs_lat", 32'(n), 32'(SYNC + 2));
        model_apply(1'b0, 2'd1, 32'h1234_5678);
        cfg_req = 1'b0;
        n = 0;
        do begin @(posedge HCLK); #1; n++; end while (cfg_ack && n < 20);
        check("midrst_fall_lat", 32'(n), 32'(SYNC + 1));
        check_regs("midrst_after");

        // Randomised traffic
        for (int t = 0; t < 60; t++) begin
            a = 2'($urandom_range(0, 3));
            run_txn("rnd", 1'($urandom_range(0, 1)), a, $urandom,
                    $urandom_range(0, 3), $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fll_cfg_responder.md
Name: fll_cfg_responder

Overview:
- FLL-side end of the 4-phase req/ack configuration link driven by the APB FLL bridge.
- Synchronises the incoming request, then decodes the write/read and 2-bit address. Writes update a 4-entry register map; reads return data.
- Drives the ack handshake back to the bridge and presents configuration registers and update strobes to the FLL core.

Parameters:
- SYNC_STAGES, 2, number of flops in the cfg_req synchroniser; legal range 2..3.
- CFG1_RST, 32'h0000_05F5, reset value of CFG1.
- CFG2_RST, 32'h0004_0107, reset value of CFG2.
- INTEG_RST, 32'h0000_0000, reset value of the integrator shadow register.

Ports:
- HCLK  in  1  FLL-domain clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- cfg_req  in  1  request from the bridge; asynchronous to HCLK.
- cfg_wrn  in  1  1 = read, 0 = write; bundled with cfg_req.
- cfg_add  in  2  register address; bundled with cfg_req.
- cfg_data  in  32  write data; bundled with cfg_req.
- cfg_ack  out  1  acknowledge to the bridge.
- cfg_r_data  out  32  read data; stable while cfg_ack=1.
- cfg1_o  out  32  CFG1 register.
- cfg2_o  out  32  CFG2 register.
- integ_o  out  32  integrator load value.
- integ_ld_o  out  1  one-cycle strobe: load integ_o into the FLL integrator.
- cfg_upd_o  out  1  one-cycle strobe on any CFG1/CFG2 write.
- status_i  in  32  live status from core: bit31 lock, [15:0] measured multiplication factor.
- integ_i  in  32  live integrator value from core.

Behaviour:
- Reset (async, HRESETn low) values:
  - cfg_ack=0, cfg_r_data=0.
  - cfg1_o=CFG1_RST, cfg2_o=CFG2_RST, integ_o=INTEG_RST.
  - Strobes 0, synchroniser flops 0, state IDLE.
- Synchroniser: req_s is cfg_req through SYNC_STAGES flops. Only req_s is used by the FSM; cfg_wrn/cfg_add/cfg_data are sampled only in IDLE when req_s=1. They are guaranteed stable because the bridge holds them from req rise until it sees ack.
- FSM states: IDLE, ACCESS, ACK, WAIT_REL.
  - IDLE: on req_s=1, capture wrn/add/data into internal regs and go to ACCESS.
  - ACCESS (1 cycle):
    - Write, add 0 (STATUS): ignored, no strobe.
    - Write, add 1: CFG1<=data, cfg_upd_o=1.
    - Write, add 2: CFG2<=data, cfg_upd_o=1.
    - Write, add 3: integ_o<=data, integ_ld_o=1.
    - Read: cfg_r_data <= status_i / cfg1_o / cfg2_o / integ_i for add 0/1/2/3.
    - Next state ACK.
  - ACK: cfg_ack=1 (registered). Go to WAIT_REL.
  - WAIT_REL: cfg_ack held 1; when req_s=0, cfg_ack<=0 and go to IDLE.
- Latency: cfg_ack rises SYNC_STAGES+2 HCLK edges after cfg_req rises; it falls SYNC_STAGES+1 edges after cfg_req falls.
- cfg_r_data: updated only in ACCESS for reads. It holds its value through ACK/WAIT_REL and afterwards until the next read; writes leave it unchanged.
- Strobes: exactly one HCLK wide, asserted in the cycle the register updates, so register and strobe are visible together.
- Boundary conditions:
  - req_s dropping before ACCESS/ACK completes (protocol violation): the transaction still completes. Ack pulses for at least 1 cycle, then returns to IDLE once req_s=0.
  - cfg_req re-asserted while in WAIT_REL: ignored until IDLE is reached (full 4-phase enforced; no back-to-back without ack drop).
  - HRESETn asserted mid-transaction: immediate return to IDLE, cfg_ack=0, registers to reset values. A pending bridge request then re-handshakes from IDLE.
  - Read of add 3 returns the live integ_i, not integ_o.

Decomposition:
- Package fll_cfg_pkg:
  - Address constants FLL_STATUS=2'd0, FLL_CFG1=2'd1, FLL_CFG2=2'd2, FLL_INTEG=2'd3.
  - FSM state enum.
  - Default reset constants.
  - Status bit positions (LOCK_BIT=31, MULT_LSB=0, MULT_W=16).
- Sub-module fll_sync_ff: a parameterised SYNC_STAGES flop chain with async reset, reusable for ack synchronisation on the bridge side.

Test Plan:
- Reset: release HRESETn -> cfg1_o=0x05F5, cfg2_o=0x0004_0107, integ_o=0, cfg_ack=0, strobes 0.
- Write CFG1: req=1, wrn=0, add=1, data=0xDEAD_BEEF -> cfg_upd_o one pulse, cfg1_o=0xDEAD_BEEF, cfg_ack=1 after 4 edges (SYNC_STAGES=2); drop req -> ack=0 after 3 edges.
- Read STATUS: status_i=0x8000_0123, req=1, wrn=1, add=0 -> cfg_r_data=0x8000_0123 stable for entire ack-high period, no strobes.
- Write INTEG then read: write add=3 data=0x55 -> integ_ld_o pulse, integ_o=0x55. Read add=3 with integ_i=0x77 -> cfg_r_data=0x77.
- Write STATUS: add=0 data=0xFFFF_FFFF -> ack completes, no strobe, cfg1/cfg2/integ_o unchanged.
- Reset mid-handshake: assert HRESETn in WAIT_REL -> cfg_ack=0 immediately, state IDLE. Keep req high after release -> new full handshake, ack rises again.
